// File: rtl/uart_transmitter.sv
// UART transmitter: 8 data bits, LSB first, 1 or 2 stop bits, idle-high line.
// A one-byte holding register in front of the shifter lets frames run back to back.
module uart_transmitter #(
    parameter int BAUD_RATE       = 9600,
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int STOP_BITS       = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       uart,
    output logic       busy
);

    localparam int DIV = (CLOCK_FREQUENCY + BAUD_RATE / 2) / BAUD_RATE;
    localparam int CW  = $clog2(DIV + 1);

    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] DIV_ONE   = CW'(1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    index_q, index_d;
    logic [CW-1:0] div_q, div_d;
    logic          stop_idx_q, stop_idx_d;
    logic          uart_q, uart_d;

    logic          accept;
    logic          load;
    logic [2:0]    next_index;

    assign uart = uart_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        index_d     = index_q;
        div_d       = div_q;
        stop_idx_d  = stop_idx_q;
        uart_d      = uart_q;
        load        = 1'b0;
        next_index  = index_q + 3'd1;

        ready  = !hold_full_q;
        busy   = (state_q != IDLE) || hold_full_q;
        accept = valid && !hold_full_q;

        // uart_d is the level for the cycle after this edge, so each branch
        // drives the value belonging to the state being entered.
        case (state_q)
            IDLE: begin
                uart_d = 1'b1;
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (div_q == '0) begin
                    state_d = DATA;
                    index_d = 3'd0;
                    div_d   = DIV_LAST;
                    uart_d  = shift_q[0];
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            DATA: begin
                if (div_q == '0) begin
                    div_d = DIV_LAST;
                    if (index_q == 3'd7) begin
                        state_d    = STOP;
                        stop_idx_d = 1'b0;
                        uart_d     = 1'b1;
                    end else begin
                        index_d = next_index;
                        uart_d  = shift_q[next_index];
                    end
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            STOP: begin
                if (div_q == '0) begin
                    if (stop_idx_q != LAST_STOP) begin
                        stop_idx_d = 1'b1;
                        div_d      = DIV_LAST;
                    end else if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        uart_d  = 1'b1;
                    end
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                uart_d  = 1'b1;
            end
        endcase

        if (load) begin
            state_d     = START;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            div_d       = DIV_LAST;
            index_d     = 3'd0;
            uart_d      = 1'b0;
        end

        // load requires hold_full, accept requires !hold_full: never both
        if (accept) begin
            hold_d      = data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            index_q     <= '0;
            div_q       <= '0;
            stop_idx_q  <= 1'b0;
            uart_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            index_q     <= index_d;
            div_q       <= div_d;
            stop_idx_q  <= stop_idx_d;
            uart_q      <= uart_d;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a 1-stop and a 2-stop instance driven side by side,
// every output compared each cycle against a frame-schedule reference model.
module tb_uart_transmitter;

    localparam int DIV = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data [2];
    logic [1:0] valid;
    logic [1:0] ready;
    logic [1:0] uart;
    logic [1:0] busy;

    always #5 clock = ~clock;

    uart_transmitter #(
        .BAUD_RATE       (10000000),
        .CLOCK_FREQUENCY (100000000),
        .STOP_BITS       (1)
    ) dut_s1 (
        .clock (clock),
        .reset (reset),
        .data  (data[0]),
        .valid (valid[0]),
        .ready (ready[0]),
        .uart  (uart[0]),
        .busy  (busy[0])
    );

    uart_transmitter #(
        .BAUD_RATE       (10000000),
        .CLOCK_FREQUENCY (100000000),
        .STOP_BITS       (2)
    ) dut_s2 (
        .clock (clock),
        .reset (reset),
        .data  (data[1]),
        .valid (valid[1]),
        .ready (ready[1]),
        .uart  (uart[1]),
        .busy  (busy[1])
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, actual, expected);
        end
    endtask

    // Reference model: each frame is a start edge plus a byte; the line level
    // follows from the offset into the frame. A held byte loads at the later of
    // the edge after acceptance and the end of the frame in flight.
    int         edge_n = 0;
    bit         m_hold     [2] = '{0, 0};
    logic [7:0] m_hold_byte[2];
    int         m_load_at  [2];
    bit         m_cur      [2] = '{0, 0};
    int         m_start    [2];
    logic [7:0] m_byte     [2];
    int         m_end      [2] = '{0, 0};
    bit         m_acc      [2];

    function automatic int flen(input int i);
        return (10 + i) * DIV;
    endfunction

    function automatic bit in_frame(input int i);
        return m_cur[i] && (edge_n < m_start[i] + flen(i));
    endfunction

    function automatic logic exp_uart(input int i);
        int         k;
        logic [7:0] b;
        if (!in_frame(i)) return 1'b1;
        k = (edge_n - m_start[i]) / DIV;
        b = m_byte[i];
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clock);
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0;
            if (reset) begin
                m_hold[i] = 0;
                m_cur[i]  = 0;
                m_end[i]  = 0;
            end else if (m_hold[i] && edge_n == m_load_at[i]) begin
                m_cur[i]   = 1;
                m_start[i] = edge_n;
                m_byte[i]  = m_hold_byte[i];
                m_end[i]   = edge_n + flen(i);
                m_hold[i]  = 0;
            end else if (valid[i] && !m_hold[i]) begin
                m_hold[i]      = 1;
                m_hold_byte[i] = data[i];
                m_load_at[i]   = (m_end[i] > edge_n + 1) ? m_end[i] : edge_n + 1;
                m_acc[i]       = 1;
            end
        end
        @(negedge clock);
        check("uart_s1",  32'(uart[0]),  32'(exp_uart(0)));
        check("ready_s1", 32'(ready[0]), 32'(!m_hold[0]));
        check("busy_s1",  32'(busy[0]),  32'(in_frame(0) || m_hold[0]));
        check("uart_s2",  32'(uart[1]),  32'(exp_uart(1)));
        check("ready_s2", 32'(ready[1]), 32'(!m_hold[1]));
        check("busy_s2",  32'(busy[1]),  32'(in_frame(1) || m_hold[1]));
    endtask

    task automatic send_both(input logic [7:0] b);
        bit done [2] = '{0, 0};
        int n = 0;
        valid   = 2'b11;
        data[0] = b;
        data[1] = b;
        while (!(done[0] && done[1]) && n < 2000) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (m_acc[i]) begin
                    done[i]  = 1;
                    valid[i] = 1'b0;
                end
            end
            n++;
        end
        valid = 2'b00;
        check("send_accepted", 32'(done[0] && done[1]), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((in_frame(0) || m_hold[0] || in_frame(1) || m_hold[1]) && n < 3000) begin
            tick();
            n++;
        end
        check("drain_done", 32'(n < 3000), 32'd1);
        repeat (5) tick();
    endtask

    initial begin
        reset   = 1'b1;
        valid   = 2'b00;
        data[0] = 8'h00;
        data[1] = 8'h00;
        repeat (5) tick();
        reset = 1'b0;
        repeat (50) tick();

        send_both(8'h55);
        wait_idle();

        send_both(8'hA5);
        send_both(8'h3C);
        wait_idle();

        send_both(8'h11);
        send_both(8'h22);
        send_both(8'h33);
        wait_idle();

        // abort mid-frame with a byte waiting in the holding register
        send_both(8'hF0);
        send_both(8'h81);
        repeat (5 * DIV) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send_both(8'h0F);
        wait_idle();

        for (int c = 0; c < 6000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        valid[i] = 1'b1;
                        data[i]  = 8'($urandom);
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    valid[i] = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    data[i] = 8'($urandom);
                end
            end
            reset = ($urandom_range(0, 1999) == 0);
            tick();
            for (int i = 0; i < 2; i++) begin
                if (m_acc[i]) valid[i] = 1'b0;
            end
        end
        reset = 1'b0;
        valid = 2'b00;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
